seg_capture: RTL and testbench
==============================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n; no other clock or reset.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive identical samples that qualify a digit (legal range 1-255).
REQ-003 Port clk, input, 1: rising-edge system clock.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port an, input, 4: digit anodes, active-low; an[3] is the most significant digit.
REQ-006 Port seg, input, 7: cathodes {a,b,c,d,e,f,g} at bits 6..0, active-low.
REQ-007 Port out_ready, input, 1: consumer accepts out_value.
REQ-008 Port clr_err, input, 1: clears sticky error flags.
REQ-009 Port out_value, output, 16: captured frame, digit 3 in bits 15:12.
REQ-010 Port out_valid, output, 1: out_value holds an unconsumed frame.
REQ-011 Port err_pattern, output, 1: sticky; a qualified pattern was not a legal hex glyph.
REQ-012 Port err_overrun, output, 1: sticky; a frame completed while out_valid was high and out_ready was low.

Function
REQ-013 The block SHALL register an and seg once before any use (1-cycle input stage).
REQ-014 Glyph map, segments lit a..g: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg; any other pattern SHALL be illegal.
REQ-015 FSM states: IDLE, SETTLE, HOLD.
REQ-016 IDLE: when exactly one anode is low, the block SHALL record that digit index and the seg sample, clear the stability counter, and go to SETTLE.
REQ-017 SETTLE: on each cycle with the same anode and the same seg, the counter SHALL increment; when it reaches STABLE_CYCLES-1, the block SHALL qualify the digit and go to HOLD.
REQ-018 SETTLE: any anode or seg change SHALL return the FSM to IDLE in the next cycle without qualifying the digit.
REQ-019 On qualification, a legal glyph SHALL write its nibble to that digit's slot and set that slot's bit in a 4-bit capture mask.
REQ-020 On qualification, an illegal glyph SHALL set err_pattern, clear the whole capture mask, and leave all slots unchanged.
REQ-021 HOLD: the FSM SHALL stay until the anode pattern changes, then go to IDLE, so one anode period yields at most one qualification.
REQ-022 Zero anodes low, or more than one anode low, SHALL force the FSM to IDLE from any state without changing the mask.
REQ-023 When the mask becomes 4'b1111: if out_valid is low, or out_ready is high in the same cycle, out_value SHALL load the four slots and out_valid SHALL be high in the next cycle.
REQ-024 Otherwise, when the mask becomes 4'b1111, out_value SHALL hold its value and err_overrun SHALL set.
REQ-025 In both cases of REQ-023/REQ-024, the mask SHALL clear.
REQ-026 Handshake: out_valid high with out_ready high SHALL consume the frame; out_valid SHALL fall next cycle unless REQ-023 reloads in that same cycle.
REQ-027 Capture latency: out_valid SHALL rise STABLE_CYCLES+2 cycles after the final digit's first stable registered-input sample.
REQ-028 Re-qualifying an already captured digit SHALL overwrite its slot; the newest value wins.
REQ-029 clr_err SHALL clear both error flags; an error event in the same cycle SHALL take priority, so the flag stays set.

Reset
REQ-030 On rst_n low, the block SHALL asynchronously set: FSM to IDLE, counter 0, mask 0, slots 0, out_value 16'h0000, out_valid 0, err_pattern 0, err_overrun 0, input registers to all-ones (inactive).
REQ-031 Deassertion mid-scan SHALL begin a fresh frame; no partial digits survive reset.

Configuration
REQ-032 Macro SEG_CAPTURE_DP_EN SHALL control decimal-point support.
REQ-033 With SEG_CAPTURE_DP_EN defined, the block SHALL add input dp (1, active-low) and output out_dp (4); dp is qualified with seg, and out_dp loads with out_value.
REQ-034 Without SEG_CAPTURE_DP_EN, the dp and out_dp ports and their logic SHALL not exist; all other behaviour is identical.

Verification
REQ-035 Scan digits 3..0 showing 1,2,3,4, each held 10 cycles, out_ready=1 -> out_value=16'h1234, out_valid pulses once per full scan.
REQ-036 Digit 0 seg toggling every 2 cycles with STABLE_CYCLES=4 -> no qualification, mask bit 0 stays 0, no frame.
REQ-037 Digit 2 driven with pattern a+g only -> err_pattern=1, mask cleared; clr_err pulse -> err_pattern=0.
REQ-038 Two full scans (16'hABCD, then 16'h0F0F) with out_ready=0 -> out_value stays 16'hABCD, err_overrun=1.
REQ-039 an=4'b1010 (two digits active) for 20 cycles -> FSM stays IDLE, mask unchanged.
REQ-040 rst_n pulsed low after 2 of 4 digits -> all outputs at reset values; the next full scan 16'h5678 captures correctly.

Source files
------------

// File: rtl/seg_capture.sv
// Captures a multiplexed 4-digit seven-segment display scan into a 16-bit hex frame.
// Optional decimal-point capture is enabled with the SEG_CAPTURE_DP_EN macro.
module seg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
`ifdef SEG_CAPTURE_DP_EN
    input  logic        dp,
    output logic [3:0]  out_dp,
`endif
    input  logic        out_ready,
    input  logic        clr_err,
    output logic [15:0] out_value,
    output logic        out_valid,
    output logic        err_pattern,
    output logic        err_overrun
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

    state_t          state;
    logic [3:0]      an_r;
    logic [6:0]      seg_r;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;
    logic [7:0]      cnt;
    logic [1:0]      idx;
    logic            qual;
    logic [1:0]      qual_idx;
    logic [6:0]      qual_seg;
    logic [3:0]      mask;
    logic [3:0]      mask_next;
    logic [3:0][3:0] slots;

    logic            single;
    logic [1:0]      sel_idx;
    logic            same;
    logic            legal;
    logic [3:0]      nibble;
    logic [6:0]      lit;
    logic            frame_full;
    logic            load;
    logic            overrun_ev;
    logic            pattern_ev;

`ifdef SEG_CAPTURE_DP_EN
    logic       dp_r;
    logic       dp_q;
    logic       qual_dp;
    logic [3:0] slot_dp;
`endif

    always_comb begin
        single  = 1'b1;
        sel_idx = 2'd0;
        case (an_r)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: single = 1'b0;
        endcase
`ifdef SEG_CAPTURE_DP_EN
        same = (an_r == an_q) && (seg_r == seg_q) && (dp_r == dp_q);
`else
        same = (an_r == an_q) && (seg_r == seg_q);
`endif
    end

    // Glyph decode works on lit segments {a..g}, i.e. the inverted cathode sample.
    always_comb begin
        lit    = ~qual_seg;
        legal  = 1'b1;
        nibble = 4'h0;
        case (lit)
            7'h7E: nibble = 4'h0;
            7'h30: nibble = 4'h1;
            7'h6D: nibble = 4'h2;
            7'h79: nibble = 4'h3;
            7'h33: nibble = 4'h4;
            7'h5B: nibble = 4'h5;
            7'h5F: nibble = 4'h6;
            7'h70: nibble = 4'h7;
            7'h7F: nibble = 4'h8;
            7'h7B: nibble = 4'h9;
            7'h77: nibble = 4'hA;
            7'h1F: nibble = 4'hB;
            7'h4E: nibble = 4'hC;
            7'h3D: nibble = 4'hD;
            7'h4F: nibble = 4'hE;
            7'h47: nibble = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r  <= 4'hF;
            seg_r <= 7'h7F;
`ifdef SEG_CAPTURE_DP_EN
            dp_r  <= 1'b1;
`endif
        end else begin
            an_r  <= an;
            seg_r <= seg;
`ifdef SEG_CAPTURE_DP_EN
            dp_r  <= dp;
`endif
        end
    end

    // Qualification is issued as a one-cycle registered pulse carrying the digit sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            idx      <= 2'd0;
            an_q     <= 4'hF;
            seg_q    <= 7'h7F;
            qual     <= 1'b0;
            qual_idx <= 2'd0;
            qual_seg <= 7'h7F;
`ifdef SEG_CAPTURE_DP_EN
            dp_q     <= 1'b1;
            qual_dp  <= 1'b1;
`endif
        end else begin
            qual <= 1'b0;
            if (!single) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        an_q  <= an_r;
                        seg_q <= seg_r;
                        idx   <= sel_idx;
                        cnt   <= 8'd0;
`ifdef SEG_CAPTURE_DP_EN
                        dp_q  <= dp_r;
`endif
                        if (LAST == 8'd0) begin
                            qual     <= 1'b1;
                            qual_idx <= sel_idx;
                            qual_seg <= seg_r;
`ifdef SEG_CAPTURE_DP_EN
                            qual_dp  <= dp_r;
`endif
                            state    <= HOLD;
                        end else begin
                            state <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (!same) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 8'd1;
                            if (cnt + 8'd1 == LAST) begin
                                qual     <= 1'b1;
                                qual_idx <= idx;
                                qual_seg <= seg_q;
`ifdef SEG_CAPTURE_DP_EN
                                qual_dp  <= dp_q;
`endif
                                state    <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (an_r != an_q) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign frame_full = (mask == 4'hF);
    assign load       = frame_full && (!out_valid || out_ready);
    assign overrun_ev = frame_full && !load;
    assign pattern_ev = qual && !legal;

    always_comb begin
        mask_next = frame_full ? 4'h0 : mask;
        if (qual) begin
            if (legal) mask_next = mask_next | (4'b0001 << qual_idx);
            else       mask_next = 4'h0;
        end
    end

    // Error events win over clr_err in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask        <= 4'h0;
            slots       <= '0;
            out_value   <= 16'h0000;
            out_valid   <= 1'b0;
            err_pattern <= 1'b0;
            err_overrun <= 1'b0;
`ifdef SEG_CAPTURE_DP_EN
            slot_dp     <= 4'hF;
            out_dp      <= 4'hF;
`endif
        end else begin
            mask <= mask_next;
            if (qual && legal) begin
                slots[qual_idx]   <= nibble;
`ifdef SEG_CAPTURE_DP_EN
                slot_dp[qual_idx] <= qual_dp;
`endif
            end
            if (load) begin
                out_value <= slots;
                out_valid <= 1'b1;
`ifdef SEG_CAPTURE_DP_EN
                out_dp    <= slot_dp;
`endif
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (pattern_ev)   err_pattern <= 1'b1;
            else if (clr_err) err_pattern <= 1'b0;
            if (overrun_ev)   err_overrun <= 1'b1;
            else if (clr_err) err_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: scoreboard of expected frames checked whenever a frame is consumed,
// plus directed checks on latency, error flags, overrun and reset.
module tb_seg_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        out_ready;
    logic        clr_err;
    logic [15:0] out_value;
    logic        out_valid;
    logic        err_pattern;
    logic        err_overrun;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    logic [15:0] expq[$];

    // Lit segments {a..g} for hex digits 0..F.
    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg_capture #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .out_ready   (out_ready),
        .clr_err     (clr_err),
        .out_value   (out_value),
        .out_valid   (out_valid),
        .err_pattern (err_pattern),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        tick(n);
    endtask

    task automatic showDigit(input int d, input int v, input int n);
        logic [3:0] a;
        a = 4'b0001 << d;
        applyStimulus(~a, ~glyph[v], n);
    endtask

    task automatic blank(input int n);
        applyStimulus(4'hF, 7'h7F, n);
    endtask

    task automatic scan(input int v3, input int v2, input int v1, input int v0);
        showDigit(3, v3, 10);
        showDigit(2, v2, 10);
        showDigit(1, v1, 10);
        showDigit(0, v0, 10);
        blank(12);
    endtask

    // Scoreboard: every consumed frame must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            assert (expq.size() != 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_frame observed=%0h expected=none", out_value);
            end
            if (expq.size() != 0) begin
                logic [15:0] e;
                e = expq.pop_front();
                checks++;
                assert (out_value === e) else begin
                    errors++;
                    $error("[TB] FAIL frame_value observed=%0h expected=%0h", out_value, e);
                end
                frames++;
            end
        end
    end

    initial begin
        rst_n = 1'b0; an = 4'hF; seg = 7'h7F; out_ready = 1'b1; clr_err = 1'b0;
        tick(2);
        checkOutput("reset_value", out_value, 16'h0000);
        checkOutput("reset_valid", out_valid, 1'b0);
        checkOutput("reset_errpat", err_pattern, 1'b0);
        checkOutput("reset_errovr", err_overrun, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // Basic scan with latency measured on the last digit
        expq.push_back(16'h1234);
        showDigit(3, 1, 10);
        showDigit(2, 2, 10);
        showDigit(1, 3, 10);
        blank(4);
        applyStimulus(4'b1110, ~glyph[4], 6);
        checkOutput("latency_early", out_valid, 1'b0);
        tick(1);
        checkOutput("latency_rise", out_valid, 1'b1);
        checkOutput("latency_value", out_value, 16'h1234);
        tick(1);
        checkOutput("valid_pulse", out_valid, 1'b0);
        tick(8);
        blank(4);
        expq.push_back(16'h1234);
        scan(1, 2, 3, 4);
        checkOutput("scan_frames", frames, 2);
        checkOutput("scan_queue", expq.size(), 0);

        // Unstable digit 0 never qualifies; mask keeps digits 3..1
        showDigit(3, 9, 10);
        showDigit(2, 8, 10);
        showDigit(1, 7, 10);
        for (int i = 0; i < 10; i++)
            applyStimulus(4'b1110, (i % 2 == 1) ? ~glyph[6] : ~glyph[5], 2);
        blank(8);
        checkOutput("toggle_noframe", frames, 2);
        checkOutput("toggle_valid", out_valid, 1'b0);
        expq.push_back(16'h9870);
        showDigit(0, 0, 10);
        blank(10);
        checkOutput("toggle_resume", frames, 3);

        // Illegal glyph clears mask and flags err_pattern
        showDigit(3, 1, 10);
        applyStimulus(4'b1011, ~7'h41, 10);
        checkOutput("illegal_errpat", err_pattern, 1'b1);
        blank(2);
        showDigit(2, 12, 10);
        showDigit(1, 5, 10);
        showDigit(0, 6, 10);
        blank(10);
        checkOutput("illegal_maskclr", frames, 3);
        expq.push_back(16'hAC56);
        showDigit(3, 10, 10);
        blank(10);
        checkOutput("illegal_refill", frames, 4);
        checkOutput("errpat_sticky", err_pattern, 1'b1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checkOutput("errpat_clear", err_pattern, 1'b0);
        checkOutput("errovr_quiet", err_overrun, 1'b0);

        // Overrun with consumer stalled
        out_ready = 1'b0;
        scan(10, 11, 12, 13);
        checkOutput("stall_valid", out_valid, 1'b1);
        checkOutput("stall_value", out_value, 16'hABCD);
        scan(0, 15, 0, 15);
        checkOutput("overrun_value", out_value, 16'hABCD);
        checkOutput("overrun_flag", err_overrun, 1'b1);
        checkOutput("overrun_valid", out_valid, 1'b1);
        expq.push_back(16'hABCD);
        out_ready = 1'b1;
        tick(1);
        checkOutput("consume_fall", out_valid, 1'b0);
        checkOutput("consume_frames", frames, 5);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checkOutput("errovr_clear", err_overrun, 1'b0);

        // Two anodes low holds the FSM idle and keeps the mask
        showDigit(3, 7, 10);
        showDigit(2, 14, 10);
        applyStimulus(4'b1010, ~glyph[3], 20);
        checkOutput("multi_noframe", frames, 5);
        expq.push_back(16'h7E39);
        showDigit(1, 3, 10);
        showDigit(0, 9, 10);
        blank(10);
        checkOutput("multi_frames", frames, 6);

        // Reset mid-scan discards the partial frame
        showDigit(3, 5, 10);
        showDigit(2, 6, 10);
        rst_n = 1'b0;
        #2;
        checkOutput("midrst_value", out_value, 16'h0000);
        checkOutput("midrst_valid", out_valid, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        showDigit(1, 7, 10);
        showDigit(0, 8, 10);
        blank(10);
        checkOutput("midrst_partial", frames, 6);
        expq.push_back(16'h5678);
        scan(5, 6, 7, 8);
        checkOutput("midrst_frames", frames, 7);
        checkOutput("final_queue", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
